plaintext_validator: RTL and testbench

//  Downstream consumer of the RC4 decrypt core. After each decrypt pass it scans RAM-A
//  (decrypted message) byte by byte and accepts the candidate key only if every byte is

---
 rtl/plaintext_validator.sv | 133 +++++++++++++
 tb/tb_plaintext_validator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plaintext_validator.sv
// plaintext_validator
//   Scans the decrypted message in RAM-A after each RC4 decrypt pass. The
//   candidate key is accepted only if every byte is a space or a lowercase ASCII
//   letter. For each pass the block gives a one-cycle verdict. The first accepted
//   key is latched for display, and a sticky success flag stops the key search.
//
// Ports
//   clk        : system clock, all logic on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : 1-cycle pulse, decrypt pass finished and RAM-A stable
//   key        : key of this pass, sampled when start is accepted
//   aAddr      : RAM-A read address
//   aOut       : RAM-A read data, valid one cycle after aAddr
//   busy       : high from accepted start until the verdict cycle
//   done       : 1-cycle pulse, verdict ready
//   valid      : verdict (1 = every byte legal), held until the next accepted start
//   success    : sticky, a legal message has been found
//   found_key  : key of the first legal pass, 0 until one is found
module plaintext_validator #(
  parameter int RAM_WIDTH          = 8,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int KEY_LENGTH         = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [KEY_LENGTH*RAM_WIDTH-1:0]  key,
  output logic [MESSAGE_LOG_LENGTH-1:0]    aAddr,
  input  logic [RAM_WIDTH-1:0]             aOut,
  output logic                             busy,
  output logic                             done,
  output logic                             valid,
  output logic                             success,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]  found_key
);

  localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;
  localparam logic [MESSAGE_LOG_LENGTH-1:0] IDX_LAST =
    MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                        state, state_nxt;
  logic [MESSAGE_LOG_LENGTH-1:0] idx;
  logic [KEY_W-1:0]              key_q;
  logic                          start_ok;
  logic                          byte_ok;
  logic                          last_byte;

  // A space or 'a'..'z' is legal. Backtick and '{' sit just outside the
  // letter range, so the bounds are inclusive on both ends.
  function automatic logic is_legal(input logic [RAM_WIDTH-1:0] b);
    return (b == RAM_WIDTH'(8'h20)) ||
           ((b >= RAM_WIDTH'(8'h61)) && (b <= RAM_WIDTH'(8'h7A)));
  endfunction

  assign byte_ok   = is_legal(aOut);
  assign last_byte = (idx == IDX_LAST);
  assign aAddr     = idx;

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    case (state)
      // Once a legal key has been found the search is over, so start is ignored.
      S_IDLE: begin
        if (start && !success) begin
          start_ok  = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR:  state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CHECK;
      // The scan exits early on the first illegal byte.
      S_CHECK: begin
        if (!byte_ok || last_byte) state_nxt = S_DONE;
        else                       state_nxt = S_ADDR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control: state, scan index, and registered flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      success   <= 1'b0;
      found_key <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == S_ADDR) || (state_nxt == S_WAIT) ||
               (state_nxt == S_CHECK);
      done  <= (state_nxt == S_DONE);

      if (start_ok) begin
        idx   <= '0;
        valid <= 1'b0;
      end

      // valid was cleared on start, so an illegal byte leaves it at 0.
      if (state == S_CHECK) begin
        if (byte_ok) begin
          if (last_byte) valid <= 1'b1;
          else           idx   <= idx + MESSAGE_LOG_LENGTH'(1);
        end
      end

      // success blocks further starts, so only the first legal key is kept.
      if ((state == S_DONE) && valid) begin
        success   <= 1'b1;
        found_key <= key_q;
      end
    end
  end

  // Capture of the key for this pass.
  always_ff @(posedge clk) begin
    if (start_ok) key_q <= key;
  end

endmodule

// File: tb/tb_plaintext_validator.sv
module tb_plaintext_validator;
  localparam int RW = 8;
  localparam int LL = 5;
  localparam int ML = 32;
  localparam int KL = 3;
  localparam int KW = KL * RW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] key = '0;
  logic [LL-1:0] aAddr;
  logic [RW-1:0] aOut;
  logic          busy, done, valid, success;
  logic [KW-1:0] found_key;

  logic [7:0] mem [0:ML-1];
  int checks = 0;
  int errors = 0;

  // Behavioural model state: one pass is described by the number of bytes
  // examined (k), the verdict, and the cycle count since the start was accepted.
  bit            m_act;
  int            m_t, m_k;
  bit            m_ok;
  logic [KW-1:0] m_kq;
  logic [LL-1:0] e_aaddr;
  bit            e_busy, e_done, e_valid, e_success;
  logic [KW-1:0] e_found;

  always #5 clk = ~clk;

  // RAM-A: synchronous read, one cycle of latency.
  always @(posedge clk) aOut <= mem[aAddr];

  plaintext_validator #(
    .RAM_WIDTH(RW), .MESSAGE_LOG_LENGTH(LL), .MESSAGE_LENGTH(ML), .KEY_LENGTH(KL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .aAddr(aAddr),
    .aOut(aOut), .busy(busy), .done(done), .valid(valid), .success(success),
    .found_key(found_key)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_b(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  task automatic model_reset();
    m_act = 0; m_t = 0; m_k = 1; m_ok = 0; m_kq = '0;
    e_aaddr = '0; e_busy = 0; e_done = 0; e_valid = 0; e_success = 0; e_found = '0;
  endtask

  task automatic model_outputs();
    if (m_act) begin
      e_busy  = (m_t <= 3 * m_k);
      e_done  = (m_t == 3 * m_k + 1);
      e_aaddr = LL'(((m_t - 1) / 3 < m_k) ? (m_t - 1) / 3 : m_k - 1);
      if (e_done) e_valid = m_ok;
    end else begin
      e_busy = 0;
      e_done = 0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs the DUT will sample.
  task automatic model_step();
    if (!reset) begin
      model_reset();
    end else if (m_act) begin
      m_t++;
      if (m_t == 3 * m_k + 2) begin
        m_act = 0;
        if (m_ok) begin
          e_success = 1;
          e_found   = m_kq;
        end
      end
    end else if (start && !e_success) begin
      m_act = 1; m_t = 1; m_kq = key; e_valid = 0;
      m_k = ML; m_ok = 1;
      for (int i = 0; i < ML; i++) begin
        if (!legal_b(mem[i])) begin
          m_k = i + 1;
          m_ok = 0;
          break;
        end
      end
    end
    model_outputs();
  endtask

  // Compare process: checks DUT outputs against the model in every cycle.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!reset) model_reset();
      chk("aAddr", 32'(aAddr), 32'(e_aaddr));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("valid", 32'(valid), 32'(e_valid));
      chk("success", 32'(success), 32'(e_success));
      chk("found_key", 32'(found_key), 32'(e_found));
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load_string();
    string s;
    s = "the quick brown fox jumps over x";
    for (int i = 0; i < ML; i++) mem[i] = s[i];
  endtask

  task automatic load_legal();
    int r;
    for (int i = 0; i < ML; i++) begin
      r = $urandom_range(0, 26);
      mem[i] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
    end
  endtask

  // Pulse start with key k and count cycles until done (cycle 1 = first edge).
  task automatic run_pass(input logic [KW-1:0] k, output int cyc);
    start = 1'b1;
    key   = k;
    cyc   = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    int cyc;
    int seen;
    int ndone;
    int first_done;
    int t;
    logic [7:0] b;

    for (int i = 0; i < ML; i++) mem[i] = 8'h20;
    tick();
    tick();
    chk("rst_aAddr", 32'(aAddr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_found_key", 32'(found_key), 32'd0);
    reset = 1'b1;
    tick();

    // Uppercase at byte 5: the scan exits after 6 bytes.
    load_string();
    mem[5] = 8'h41;
    run_pass(24'h111111, cyc);
    chk("t2_latency", 32'(cyc), 32'd19);
    chk("t2_valid", 32'(valid), 32'd0);
    chk("t2_aAddr", 32'(aAddr), 32'd5);
    tick();
    chk("t2_success", 32'(success), 32'd0);

    // Bytes just outside the legal ranges.
    load_string();
    mem[0] = 8'h7B;
    run_pass(24'h222222, cyc);
    chk("b7B_latency", 32'(cyc), 32'd4);
    chk("b7B_valid", 32'(valid), 32'd0);
    tick();
    mem[0] = 8'h60;
    run_pass(24'h333333, cyc);
    chk("b60_latency", 32'(cyc), 32'd4);
    chk("b60_valid", 32'(valid), 32'd0);
    tick();
    mem[0] = 8'h00;
    run_pass(24'h444444, cyc);
    chk("b00_valid", 32'(valid), 32'd0);
    tick();
    mem[0] = 8'h5A;
    run_pass(24'h555555, cyc);
    chk("b5A_valid", 32'(valid), 32'd0);
    tick();

    // Range end points, with a space at the last byte.
    mem[0] = 8'h61;
    mem[1] = 8'h7A;
    mem[31] = 8'h20;
    run_pass(24'h123456, cyc);
    chk("bnd_latency", 32'(cyc), 32'd97);
    chk("bnd_valid", 32'(valid), 32'd1);
    tick();
    chk("bnd_success", 32'(success), 32'd1);
    chk("bnd_found", 32'(found_key), 32'h123456);
    do_reset();
    chk("rst2_success", 32'(success), 32'd0);
    chk("rst2_found", 32'(found_key), 32'd0);

    // An illegal pass, then a legal pass, then a third pass that must be ignored.
    load_string();
    mem[10] = 8'h7B;
    run_pass(24'h0000A1, cyc);
    chk("t4_p1_valid", 32'(valid), 32'd0);
    tick();
    load_string();
    run_pass(24'h0000B2, cyc);
    chk("t4_p2_valid", 32'(valid), 32'd1);
    tick();
    chk("t4_found", 32'(found_key), 32'h0000B2);
    start = 1'b1;
    key = 24'h0000C3;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      start = 1'b0;
      if (busy || done) seen++;
    end
    chk("t4_p3_ignored", 32'(seen), 32'd0);
    chk("t4_found_kept", 32'(found_key), 32'h0000B2);
    do_reset();

    // Extra start pulses during a scan are ignored.
    load_string();
    start = 1'b1;
    key = 24'h00C1C1;
    ndone = 0;
    first_done = 0;
    for (t = 1; t <= 130; t++) begin
      tick();
      if (t == 1) start = 1'b0;
      if (t == 2 || t == 9) begin
        start = 1'b1;
        key = 24'h00C2C2;
      end
      if (t == 3 || t == 10) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = t;
      end
    end
    chk("t5_ndone", 32'(ndone), 32'd1);
    chk("t5_done_cycle", 32'(first_done), 32'd97);
    chk("t5_found", 32'(found_key), 32'h00C1C1);
    do_reset();

    // Asynchronous reset in the middle of a scan.
    load_string();
    start = 1'b1;
    key = 24'h00D1D1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    chk("t6_pre_aAddr", 32'(aAddr), 32'd6);
    #2 reset = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_aAddr", 32'(aAddr), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    run_pass(24'h00D2D2, cyc);
    chk("t6_latency", 32'(cyc), 32'd97);
    tick();
    chk("t6_found", 32'(found_key), 32'h00D2D2);
    do_reset();

    // Fully legal message.
    load_string();
    run_pass(24'h0A0B0C, cyc);
    chk("t1_latency", 32'(cyc), 32'd97);
    chk("t1_valid", 32'(valid), 32'd1);
    tick();
    chk("t1_success", 32'(success), 32'd1);
    chk("t1_found", 32'(found_key), 32'h0A0B0C);

    // Randomized passes, checked cycle by cycle against the model.
    for (int p = 0; p < 60; p++) begin
      if (success || $urandom_range(0, 7) == 0) do_reset();
      load_legal();
      if ($urandom_range(0, 2) != 0) begin
        do b = 8'($urandom); while (legal_b(b));
        mem[$urandom_range(0, ML - 1)] = b;
      end
      start = 1'b1;
      key = KW'($urandom);
      tick();
      start = 1'b0;
      for (int j = 0; j < int'($urandom_range(0, 110)); j++) begin
        start = ($urandom_range(0, 15) == 0);
        key = KW'($urandom);
        if ($urandom_range(0, 300) == 0) reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      start = 1'b0;
      for (int j = 0; j < 150; j++) begin
        if (!busy && !done) break;
        tick();
      end
      chk("rnd_idle", 32'(busy || done), 32'd0);
    end

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
